// File: rtl/matrix_row_loader_pkg.sv
// rtl/matrix_row_loader_pkg.sv - shared constants and state encoding for the matrix row loader
//
// Purpose: default geometry of one operand matrix (element width, elements per
// row, row width, bank depth) so the multiplier datapath can reuse it, plus
// the loader FSM state type.

package matrix_row_loader_pkg;

    localparam int ELEM_W    = 32;
    localparam int ROW_ELEMS = 32;
    localparam int ROW_W     = ELEM_W * ROW_ELEMS;
    localparam int NUM_ROWS  = 32;
    localparam int ROW_IDX_W = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        WRITE    = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } loader_state_t;

endpackage

// File: rtl/matrix_row_loader_row_packer.sv
// rtl/matrix_row_loader_row_packer.sv - packs a stream of elements into one row buffer
//
// Purpose: holds the row buffer and the element counter. Each push stores
// in_data into the slice selected by the counter (element 0 in the LSBs).
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart packing at element 0 (buffer contents are kept)
//   push      - an element is accepted this cycle
//   in_data   - element value
//   row       - current row buffer
//   row_full  - the push this cycle stores the last element of the row

module matrix_row_loader_row_packer #(
    parameter int ELEM_W    = matrix_row_loader_pkg::ELEM_W,
    parameter int ROW_ELEMS = matrix_row_loader_pkg::ROW_ELEMS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic [ELEM_W-1:0]             in_data,
    output logic [ELEM_W*ROW_ELEMS-1:0]   row,
    output logic                          row_full
);
    import matrix_row_loader_pkg::*;

    localparam int CNT_W = (ROW_ELEMS > 1) ? $clog2(ROW_ELEMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROW_ELEMS - 1);

    logic [CNT_W-1:0]              elem_cnt;
    logic [ELEM_W*ROW_ELEMS-1:0]   row_buf;

    assign row      = row_buf;
    assign row_full = push && (elem_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_cnt <= '0;
            row_buf  <= '0;
        end else if (clear) begin
            elem_cnt <= '0;
        end else if (push) begin
            // Slice decode written as a loop so the write stays a fixed-width
            // part-select per element rather than a variable shift.
            for (int k = 0; k < ROW_ELEMS; k++) begin
                if (elem_cnt == CNT_W'(k)) begin
                    row_buf[k*ELEM_W +: ELEM_W] <= in_data;
                end
            end
            elem_cnt <= row_full ? '0 : elem_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/matrix_row_loader.sv
// rtl/matrix_row_loader.sv - fills the bank of row registers from an element stream
//
// Purpose: accepts elements over a valid/ready handshake, packs ROW_ELEMS of
// them per row, writes each row to the next row register with a one-cycle
// enable, waits for that register's ready, and pulses load_done after the
// last row.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - begin a load (only honoured in IDLE)
//   in_data/in_valid/in_ready - element stream handshake
//   reg_enable   - one-hot write enable per row register
//   reg_data     - packed row, shared by all row registers
//   reg_ready    - ready flags from the row registers
//   row_idx      - row being filled or written
//   busy         - high outside IDLE
//   load_done    - one-cycle pulse when the whole matrix is loaded

module matrix_row_loader #(
    parameter int ELEM_W    = matrix_row_loader_pkg::ELEM_W,
    parameter int ROW_ELEMS = matrix_row_loader_pkg::ROW_ELEMS,
    parameter int NUM_ROWS  = matrix_row_loader_pkg::NUM_ROWS,
    parameter int ROW_IDX_W = matrix_row_loader_pkg::ROW_IDX_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ELEM_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_ROWS-1:0]           reg_enable,
    output logic [ELEM_W*ROW_ELEMS-1:0]   reg_data,
    input  logic [NUM_ROWS-1:0]           reg_ready,
    output logic [ROW_IDX_W-1:0]          row_idx,
    output logic                          busy,
    output logic                          load_done
);
    import matrix_row_loader_pkg::*;

    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(NUM_ROWS - 1);

    loader_state_t          state_q, state_d;
    logic [ROW_IDX_W-1:0]   row_idx_q, row_idx_d;
    logic                   push;
    logic                   clear;
    logic                   row_full;
    logic                   row_ack;

    // in_ready is a pure state decode, so there is no path from in_valid.
    assign in_ready  = (state_q == FILL);
    assign busy      = (state_q != IDLE);
    assign load_done = (state_q == DONE);
    assign row_idx   = row_idx_q;
    assign push      = in_valid && in_ready;
    assign clear     = (state_q == IDLE) && start;

    matrix_row_loader_row_packer #(
        .ELEM_W    (ELEM_W),
        .ROW_ELEMS (ROW_ELEMS)
    ) u_row_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .push     (push),
        .in_data  (in_data),
        .row      (reg_data),
        .row_full (row_full)
    );

    // Only the ready bit of the row just written matters; others are ignored.
    always_comb begin
        row_ack = 1'b0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (row_idx_q == ROW_IDX_W'(i)) begin
                row_ack = reg_ready[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        reg_enable = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FILL;
                    row_idx_d = '0;
                end
            end
            FILL: begin
                if (row_full) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                for (int i = 0; i < NUM_ROWS; i++) begin
                    if (row_idx_q == ROW_IDX_W'(i)) begin
                        reg_enable[i] = 1'b1;
                    end
                end
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (row_ack) begin
                    if (row_idx_q == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        row_idx_d = row_idx_q + 1'b1;
                        state_d   = FILL;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_row_loader.sv
// tb/tb_matrix_row_loader.sv - self-checking bench for matrix_row_loader

module tb_matrix_row_loader;

    localparam int EW = 32;
    localparam int RE = 32;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int RW = EW * RE;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [EW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [NR-1:0]   reg_enable;
    logic [RW-1:0]   reg_data;
    logic [NR-1:0]   reg_ready;
    logic [IW-1:0]   row_idx;
    logic            busy;
    logic            load_done;

    logic [NR-1:0]   ready_auto = '0;
    logic [NR-1:0]   ready_mask = '0;
    logic [NR-1:0]   ready_force = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfer_cnt = 0;

    logic [RW-1:0]   row_mem [NR];
    logic [IW-1:0]   exp_idx_q [$];
    logic [RW-1:0]   exp_row_q [$];
    logic [IW-1:0]   m_idx;
    logic [RW-1:0]   m_row;

    assign reg_ready = (ready_auto & ~ready_mask) | ready_force;

    matrix_row_loader #(
        .ELEM_W    (EW),
        .ROW_ELEMS (RE),
        .NUM_ROWS  (NR),
        .ROW_IDX_W (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reg_enable (reg_enable),
        .reg_data   (reg_data),
        .reg_ready  (reg_ready),
        .row_idx    (row_idx),
        .busy       (busy),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (in_valid && in_ready) xfer_cnt = xfer_cnt + 1;
    end

    // Row register model: captures on enable, raises ready on the same edge.
    always @(posedge clk) begin
        ready_auto <= reg_enable;
        for (int i = 0; i < NR; i++) begin
            if (reg_enable[i]) row_mem[i] <= reg_data;
        end
    end

    function automatic logic [RW-1:0] exp_row(input int r, input logic [EW-1:0] base);
        logic [RW-1:0] v;
        for (int c = 0; c < RE; c++) v[c*EW +: EW] = base + EW'(r*RE + c);
        return v;
    endfunction

    function automatic int first_diff(input logic [RW-1:0] a, input logic [RW-1:0] b);
        for (int c = 0; c < RE; c++) if (a[c*EW +: EW] !== b[c*EW +: EW]) return c;
        return -1;
    endfunction

    // Scoreboard: every row write is popped against the expected queue.
    always @(negedge clk) begin
        if (!rst && reg_enable != '0) begin
            checks = checks + 1;
            if (exp_idx_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_unexpected_write reg_enable=%b required=none", reg_enable);
            end else begin
                m_idx = exp_idx_q.pop_front();
                m_row = exp_row_q.pop_front();
                if (reg_enable !== (NR'(1) << m_idx)) begin
                    errors = errors + 1;
                    $display("FAIL sb_enable got=%b required=%b", reg_enable, NR'(1) << m_idx);
                end
                checks = checks + 1;
                if (reg_data !== m_row) begin
                    errors = errors + 1;
                    $display("FAIL sb_row_data row=%0d elem=%0d got=%h required=%h", m_idx,
                             first_diff(reg_data, m_row),
                             reg_data[first_diff(reg_data, m_row)*EW +: EW],
                             m_row[first_diff(reg_data, m_row)*EW +: EW]);
                end
            end
        end
    end

    task automatic send_elem(input logic [EW-1:0] v, input bit gap);
        int t;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            checks = checks + 1;
            if (in_ready !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL bp_in_ready got=%b required=1", in_ready);
            end
        end
        in_data  = v;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL elem_accept_timeout got=in_ready_low required=in_ready_high");
        end
        @(negedge clk);
    endtask

    task automatic stream_row(input int r, input logic [EW-1:0] base, input bit gaps,
                              input int n, input int spur_col);
        if (n == RE) begin
            exp_idx_q.push_back(IW'(r));
            exp_row_q.push_back(exp_row(r, base));
        end
        for (int c = 0; c < n; c++) begin
            start = (c == spur_col);
            send_elem(base + EW'(r*RE + c), gaps && c > 0);
        end
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int at);
        int t;
        in_valid = 1'b0;
        t = 0;
        while (load_done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        at = cyc;
        if (t >= 200) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL load_done_timeout got=0 required=1");
        end
    endtask

    task automatic check_mem(input logic [EW-1:0] base);
        for (int r = 0; r < NR; r++) begin
            checks = checks + 1;
            if (row_mem[r] !== exp_row(r, base)) begin
                errors = errors + 1;
                $display("FAIL row_mem row=%0d elem=%0d got=%h required=%h", r,
                         first_diff(row_mem[r], exp_row(r, base)),
                         row_mem[r][first_diff(row_mem[r], exp_row(r, base))*EW +: EW],
                         exp_row(r, base)[first_diff(row_mem[r], exp_row(r, base))*EW +: EW]);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks = checks + 6;
        if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready got=%b required=0", in_ready); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got=%b required=0", busy); end
        if (load_done !== 1'b0)  begin errors++; $display("FAIL rst_load_done got=%b required=0", load_done); end
        if (reg_enable !== '0)   begin errors++; $display("FAIL rst_reg_enable got=%b required=0", reg_enable); end
        if (row_idx !== '0)      begin errors++; $display("FAIL rst_row_idx got=%0d required=0", row_idx); end
        if (reg_data !== '0)     begin errors++; $display("FAIL rst_reg_data got=%h required=0", reg_data[EW-1:0]); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        int c0, at;
        pulse_start();
        c0 = cyc;
        xfer_cnt = 0;
        for (int r = 0; r < NR; r++) stream_row(r, 32'h0, 1'b0, RE, -1);
        wait_done(at);
        checks = checks + 6;
        if (at - c0 != NR*34) begin errors++; $display("FAIL full_latency got=%0d required=%0d", at - c0, NR*34); end
        if (xfer_cnt != NR*RE) begin errors++; $display("FAIL full_xfers got=%0d required=%0d", xfer_cnt, NR*RE); end
        if (row_idx !== IW'(NR-1)) begin errors++; $display("FAIL done_row_idx got=%0d required=%0d", row_idx, NR-1); end
        @(negedge clk);
        if (load_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b required=0", load_done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL done_busy got=%b required=0", busy); end
        if (exp_idx_q.size() != 0) begin errors++; $display("FAIL full_rows_written got=%0d_pending required=0", exp_idx_q.size()); end
        check_mem(32'h0);
    endtask

    task automatic test_backpressure();
        int at;
        pulse_start();
        xfer_cnt = 0;
        stream_row(0, 32'h1000_0000, 1'b1, RE, -1);
        checks = checks + 1;
        if (xfer_cnt != RE) begin errors++; $display("FAIL bp_xfers got=%0d required=%0d", xfer_cnt, RE); end
        for (int r = 1; r < NR; r++) stream_row(r, 32'h1000_0000, 1'b1, RE, -1);
        wait_done(at);
        @(negedge clk);
        check_mem(32'h1000_0000);
    endtask

    task automatic test_delayed_ack();
        int at;
        ready_mask = 4'b0001;
        pulse_start();
        // start re-pulsed on element 7 of row 0: must be ignored in FILL
        stream_row(0, 32'h2000_0000, 1'b0, RE, 7);
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ready_force = (k == 2) ? 4'b0010 : 4'b0000;
            start = (k == 2);
            @(negedge clk);
            checks = checks + 3;
            if (in_ready !== 1'b0)   begin errors++; $display("FAIL wait_in_ready k=%0d got=%b required=0", k, in_ready); end
            if (reg_enable !== '0)   begin errors++; $display("FAIL wait_reg_enable k=%0d got=%b required=0", k, reg_enable); end
            if (row_idx !== '0)      begin errors++; $display("FAIL wait_row_idx k=%0d got=%0d required=0", k, row_idx); end
        end
        start = 1'b0;
        ready_force = 4'b0001;
        @(negedge clk);
        ready_force = 4'b0000;
        ready_mask  = 4'b0000;
        checks = checks + 2;
        if (row_idx !== IW'(1)) begin errors++; $display("FAIL ack_row_idx got=%0d required=1", row_idx); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL ack_in_ready got=%b required=1", in_ready); end
        for (int r = 1; r < NR; r++) stream_row(r, 32'h2000_0000, 1'b0, RE, -1);
        wait_done(at);
        @(negedge clk);
        check_mem(32'h2000_0000);
    endtask

    task automatic test_reset_mid_fill();
        int at;
        pulse_start();
        stream_row(0, 32'h3000_0000, 1'b0, RE, -1);
        stream_row(1, 32'h3000_0000, 1'b0, RE, -1);
        stream_row(2, 32'h3000_0000, 1'b0, 10, -1);
        rst = 1'b1;
        #1;
        checks = checks + 4;
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL mid_rst_in_ready got=%b required=0", in_ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy got=%b required=0", busy); end
        if (row_idx !== '0)     begin errors++; $display("FAIL mid_rst_row_idx got=%0d required=0", row_idx); end
        if (reg_enable !== '0)  begin errors++; $display("FAIL mid_rst_reg_enable got=%b required=0", reg_enable); end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_idx_q.delete();
        exp_row_q.delete();
        @(negedge clk);
        pulse_start();
        xfer_cnt = 0;
        for (int r = 0; r < NR; r++) stream_row(r, 32'h4000_0000, 1'b0, RE, -1);
        wait_done(at);
        @(negedge clk);
        checks = checks + 1;
        if (xfer_cnt != NR*RE) begin errors++; $display("FAIL reload_xfers got=%0d required=%0d", xfer_cnt, NR*RE); end
        check_mem(32'h4000_0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_load();
        test_backpressure();
        test_delayed_ack();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_row_loader.md
Name: matrix_row_loader

Overview:
- Sequences the bank of 1024-bit row registers that hold one operand matrix for the multiplier.
- Accepts a stream of 32-bit elements over a valid/ready handshake and packs 32 of them into one 1024-bit row.
- Writes each row into the next row register with a single-cycle enable, then waits for that register's ready.
- Repeats for NUM_ROWS rows, then pulses load_done. Sits between the host/DMA element stream and the row register bank.

Parameters:
- ELEM_W, 32, width of one matrix element.
- ROW_ELEMS, 32, elements per row; ELEM_W*ROW_ELEMS = 1024 is the row register width.
- NUM_ROWS, 32, number of row registers in the bank.
- ROW_IDX_W, 5, width of the row index; equals clog2(NUM_ROWS).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a matrix load; sampled only in IDLE.
- in_data  in  ELEM_W  element value; elements arrive column 0 first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts an element this cycle.
- reg_enable  out  NUM_ROWS  one-hot write enable, one bit per row register.
- reg_data  out  ELEM_W*ROW_ELEMS  packed row, shared by all row registers.
- reg_ready  in  NUM_ROWS  ready flags returned by the row registers.
- row_idx  out  ROW_IDX_W  row currently being filled or written.
- busy  out  1  high in every state except IDLE.
- load_done  out  1  single-cycle pulse after the last row is acknowledged.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; row buffer=0; elem_cnt=0; row_idx=0; in_ready=0; reg_enable=0; busy=0; load_done=0.
- Packing: the element accepted at count k is written to bits [ELEM_W*k+ELEM_W-1 : ELEM_W*k]. Element 0 is the LSB slice; element ROW_ELEMS-1 is the MSB slice.
- reg_data continuously reflects the row buffer. The buffer changes only on accepted transfers in FILL, so it is stable throughout WRITE and WAIT_ACK.
- A transfer occurs on a rising edge where in_valid && in_ready.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> FILL; clear elem_cnt and row_idx.
- FILL:
  - in_ready=1.
  - Each transfer stores the element and increments elem_cnt.
  - A transfer with elem_cnt==ROW_ELEMS-1 -> WRITE; elem_cnt wraps to 0.
  - in_valid low stalls FILL indefinitely; the state is held.
- WRITE:
  - in_ready=0.
  - reg_enable[row_idx]=1 for exactly this one cycle; all other bits 0.
  - Unconditional transition -> WAIT_ACK.
- WAIT_ACK:
  - in_ready=0, reg_enable=0.
  - The row register raises ready on the same edge that samples its enable, so reg_ready[row_idx] is normally high in the first WAIT_ACK cycle.
  - reg_ready[row_idx]=1 and row_idx==NUM_ROWS-1 -> DONE.
  - reg_ready[row_idx]=1 otherwise -> row_idx+1, FILL.
  - reg_ready[row_idx]=0 -> stay in WAIT_ACK.
  - reg_ready bits of other rows are ignored.
- DONE:
  - load_done=1 for this one cycle; row_idx holds NUM_ROWS-1.
  - Unconditional transition -> IDLE.
- start asserted in any state other than IDLE is ignored; it does not restart the load.
- Latency: best case per row is ROW_ELEMS transfer cycles + 1 (WRITE) + 1 (WAIT_ACK) = 34 cycles. A full back-to-back load is NUM_ROWS*34 cycles followed by the 1-cycle DONE.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous). A partially filled row is discarded. Row registers already written keep their contents; they have no reset.
- in_ready is a registered-state decode (FILL only); there is no combinational path from in_valid to in_ready.
- reg_enable is at most one-hot in every cycle; no two row registers are ever written in the same cycle.

Decomposition:
- Shared package/header:
  - State encoding localparams: IDLE, FILL, WRITE, WAIT_ACK, DONE.
  - ELEM_W=32, ROW_ELEMS=32, ROW_W=1024 for reuse by the multiplier datapath.
- Optional sub-module row_packer:
  - Contains the row buffer and elem_cnt.
  - Inputs: clk, rst, clear, in_data, push.
  - Outputs: row, row_full (the last element was accepted this cycle).
- The FSM, row_idx counter and one-hot enable decode stay in matrix_row_loader.

Test Plan:
- Single row, NUM_ROWS=1:
  - Stimulus: start, then stream elements 0x00000000..0x0000001F with in_valid held high.
  - Required: exactly 32 transfers; reg_enable=1'b1 for one cycle; reg_data[31:0]=0x0, reg_data[1023:992]=0x1F; load_done pulses one cycle after ready returns; busy falls with it.
- Full load, NUM_ROWS=4:
  - Stimulus: stream element value (row*32+col) for all 4 rows.
  - Required: reg_enable sequence 0001, 0010, 0100, 1000; each row register captures its own values; total latency 4*34+1 cycles.
- Backpressure:
  - Stimulus: toggle in_valid 1,0,1,0 across the element stream.
  - Required: only cycles with in_valid high count as transfers; packing order unchanged; in_ready stays 1 throughout FILL.
- Delayed ack:
  - Stimulus: hold reg_ready[0] low for 5 cycles after WRITE.
  - Required: loader stays in WAIT_ACK with in_ready=0 and reg_enable=0; row_idx advances to 1 only after reg_ready[0]=1; reg_ready[1] pulsed during the wait is ignored.
- Reset mid-fill:
  - Stimulus: assert rst after 10 elements of row 2 have been accepted.
  - Required: immediately in_ready=0, busy=0, row_idx=0, reg_enable=0; a new start reloads from row 0, element 0.
- Spurious start:
  - Stimulus: pulse start during FILL and again in WAIT_ACK.
  - Required: no effect; elem_cnt and row_idx continue unchanged.
